param_accum_core: RTL and testbench
===================================

Name: param_accum_core

Overview:
- Parametrised successor to the 16-bit accumulator core used in the multicore array.
- Generalises data width, register count and address width, and carries the same X/Y core-ID parameters.
- Replaces fixed-timing memory reads with req/ack handshakes on both instruction and data ports, so several cores can share arbitrated memories.
- One instance per tile; sits between the tile's IMEM/DMEM arbiter ports and the array controller.

Parameters:
DW, 16, datapath width of AC, R0..R(NREG-1) and the DMEM data bus.
AW, 16, address width of PC and DMADDR; must be >= 8 and <= DW.
NREG, 8, number of general registers; must be in 2..16.
CORE_X, 0, core column ID; width DW.
CORE_Y, 0, core row ID; width DW.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start  in  1  begin execution from PC=0; sampled in IDLE and HALT
imem_req  out  1  instruction fetch request
imem_addr  out  AW  fetch address (equals PC)
imem_ack  in  1  fetch accepted; imem_rdata valid this cycle
imem_rdata  in  16  instruction word
dmem_req  out  1  data access request
dmem_we  out  1  1 = store, 0 = load
dmem_addr  out  AW  data address
dmem_wdata  out  DW  store data
dmem_ack  in  1  access complete; dmem_rdata valid this cycle for loads
dmem_rdata  in  DW  load data
busy  out  1  high in FETCH, EXEC and MEM
done  out  1  high in HALT
ac_out  out  DW  accumulator, for debug
perf_cycles  out  32  see Optional Feature
perf_retired  out  32  see Optional Feature

Behaviour:
- Reset: asynchronous on rst_n low.
  - State = IDLE; PC, AC, IR and all registers cleared; Z = 1.
  - All outputs 0 except those driven from registers, which are 0 because the registers are cleared.
- Instruction format: [15:12] opcode, [11:8] register index r, [7:0] immediate.
  - Only the low ceil(log2 NREG) bits of r are used; the upper bits are ignored.
- Opcodes (Z updated where marked: Z = (new AC == 0)):
  - 0 NOP.
  - 1 LDI: AC = zero-extended imm. Updates Z.
  - 2 MOV: R[r] = AC.
  - 3 MVA: AC = R[r]. Updates Z.
  - 4 ADD: AC = AC + R[r], mod 2^DW. Updates Z.
  - 5 SUB: AC = AC - R[r], mod 2^DW. Updates Z.
  - 6 MUL: AC = low DW bits of AC*R[r]. Updates Z.
  - 7 INC: R[r] = R[r] + 1, wraps. Z unchanged.
  - 8 LD: AC = DMEM[R[r][AW-1:0]]. Updates Z.
  - 9 ST: DMEM[R[r][AW-1:0]] = AC.
  - A JZ: if Z, PC = zero-extended imm.
  - B JMP: PC = zero-extended imm.
  - C CID: AC = imm[0] ? CORE_Y : CORE_X. Z unchanged.
  - D, E: treated as NOP.
  - F HALT.
- FSM states and transitions:
  - IDLE: on start go to FETCH with PC = 0.
  - FETCH: imem_req = 1 and imem_addr = PC, held stable until imem_ack. On ack: IR = imem_rdata, PC = PC+1 (wraps at 2^AW), go to EXEC.
  - EXEC (1 cycle): register/ALU/jump ops commit at the end of this cycle, then go to FETCH. LD/ST go to MEM. HALT goes to HALT.
  - MEM: dmem_req = 1, with dmem_we/addr/wdata driven from registers and held stable until dmem_ack. On ack: LD writes AC and Z, then go to FETCH.
  - HALT: done = 1. start returns to FETCH with PC = 0; AC and registers are retained.
- Latency with zero-wait acks (ack in the first request cycle):
  - Non-memory instruction: 2 cycles.
  - LD/ST: 3 cycles.
  - Each extra wait cycle adds 1.
- Handshake rules:
  - req is never withdrawn before ack.
  - ack while req = 0 is ignored.
  - imem and dmem requests are never asserted in the same cycle.
- Boundary conditions:
  - start while busy is ignored.
  - Jump target beyond 2^AW-1 is impossible because imm is 8 bits.
  - An ack and a reset in the same cycle: reset wins; no state is committed.
  - Reset during MEM drops dmem_req asynchronously.
- MOV/INC to a register index >= NREG: no register is written; the instruction still retires.

Optional Feature:
- Macro: PARAM_ACCUM_CORE_PERF_EN.
- Defined:
  - perf_cycles counts every cycle that busy is high.
  - perf_retired increments once per instruction leaving EXEC/MEM, including HALT.
  - Both counters wrap at 2^32, clear on reset, and clear on start.
- Undefined: both ports are tied to 0 and no counter flops are inferred.

Test Plan:
- Reset mid-MEM (ST pending, no ack), then release rst_n -> dmem_req falls immediately; state IDLE; PC=0, AC=0, Z=1, busy=0.
- Program LDI 5; MOV R1; LDI 3; ADD R1; HALT, with zero-wait acks -> ac_out=8, Z=0, done=1 after 10 cycles; perf_retired=5 with PERF_EN.
- LDI 0xFF; MOV R2; LDI 0xAA; ST R2; LDI 0; LD R2; HALT, with 3-cycle dmem ack delay -> store to address 0x00FF with wdata 0x00AA; AC=0x00AA after LD; dmem_req held 3 cycles each access.
- Countdown loop (LDI 2; MOV R1; LDI 1; MOV R3; loop: MVA R1; SUB R3; MOV R1; JZ end; JMP loop; end: HALT) -> JZ taken only on the second iteration; R1=0; done asserted.
- CID with CORE_X=3, CORE_Y=7: CID imm=0 -> AC=3; CID imm=1 -> AC=7; Z unchanged after each.
- DW=8 build, NREG=4: LDI 0xFF; MOV R0; LDI 2; MUL R0 -> AC=0xFE. INC R0 -> R0=0x00. MOV with r=5 -> no register changes.

Source files
------------

// File: rtl/param_accum_core.sv
// Parametrised accumulator core with req/ack instruction and data ports.
// Optional performance counters are enabled by defining PARAM_ACCUM_CORE_PERF_EN.
module param_accum_core #(
  parameter int              DW     = 16,
  parameter int              AW     = 16,
  parameter int              NREG   = 8,
  parameter logic [DW-1:0]   CORE_X = '0,
  parameter logic [DW-1:0]   CORE_Y = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [15:0]   imem_rdata,
  output logic          dmem_req,
  output logic          dmem_we,
  output logic [AW-1:0] dmem_addr,
  output logic [DW-1:0] dmem_wdata,
  input  logic          dmem_ack,
  input  logic [DW-1:0] dmem_rdata,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] ac_out,
  output logic [31:0]   perf_cycles,
  output logic [31:0]   perf_retired
);

  localparam int RIW = $clog2(NREG);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_MEM   = 3'd3,
    ST_HALT  = 3'd4
  } state_t;

  state_t          state_r, state_s;
  logic [AW-1:0]   pc_r, pc_s;
  logic [15:0]     ir_r;
  logic [DW-1:0]   ac_r, ac_s;
  logic            z_r, z_s, zupd_s;
  logic [DW-1:0]   regs_r [NREG];
  logic            reg_we_s;
  logic [DW-1:0]   reg_wd_s, rval_s;
  logic [3:0]      op_s;
  logic [RIW-1:0]  idx_s;
  logic [7:0]      imm_s;
  logic            imem_req_r, dmem_req_r, dmem_we_r, busy_r, done_r;
  logic [AW-1:0]   dmem_addr_r;
  logic [DW-1:0]   dmem_wdata_r;
  logic            unused_ir_s;

  assign op_s        = ir_r[15:12];
  assign idx_s       = ir_r[8 +: RIW];
  assign imm_s       = ir_r[7:0];
  // Register-index bits above RIW are ignored by design.
  assign unused_ir_s = ^ir_r[11:8];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= state_s;
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE, ST_HALT: begin
        if (start) state_s = ST_FETCH;
        else       state_s = state_r;
      end
      ST_FETCH: begin
        if (imem_ack) state_s = ST_EXEC;
        else          state_s = ST_FETCH;
      end
      ST_EXEC: begin
        case (op_s)
          4'h8, 4'h9: state_s = ST_MEM;
          4'hF:       state_s = ST_HALT;
          default:    state_s = ST_FETCH;
        endcase
      end
      ST_MEM: begin
        if (dmem_ack) state_s = ST_FETCH;
        else          state_s = ST_MEM;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Register-file read mux; indices >= NREG read as zero
  always_comb begin
    rval_s = '0;
    for (int i = 0; i < NREG; i++) begin
      rval_s = (idx_s == RIW'(i)) ? regs_r[i] : rval_s;
    end
  end

  // Datapath next values for PC, AC, Z and register write-back
  always_comb begin
    pc_s     = pc_r;
    ac_s     = ac_r;
    z_s      = z_r;
    zupd_s   = 1'b0;
    reg_we_s = 1'b0;
    reg_wd_s = ac_r;
    case (state_r)
      ST_IDLE, ST_HALT: begin
        if (start) pc_s = '0;
        else       pc_s = pc_r;
      end
      ST_FETCH: begin
        if (imem_ack) pc_s = pc_r + AW'(1);
        else          pc_s = pc_r;
      end
      ST_EXEC: begin
        case (op_s)
          4'h1: begin ac_s = DW'(imm_s);     zupd_s = 1'b1; end
          4'h2: reg_we_s = 1'b1;
          4'h3: begin ac_s = rval_s;         zupd_s = 1'b1; end
          4'h4: begin ac_s = ac_r + rval_s;  zupd_s = 1'b1; end
          4'h5: begin ac_s = ac_r - rval_s;  zupd_s = 1'b1; end
          4'h6: begin ac_s = ac_r * rval_s;  zupd_s = 1'b1; end
          4'h7: begin reg_we_s = 1'b1; reg_wd_s = rval_s + DW'(1); end
          4'hA: begin
            if (z_r) pc_s = AW'(imm_s);
            else     pc_s = pc_r;
          end
          4'hB: pc_s = AW'(imm_s);
          4'hC: ac_s = imm_s[0] ? CORE_Y : CORE_X;
          default: ac_s = ac_r;
        endcase
      end
      ST_MEM: begin
        if (dmem_ack && !dmem_we_r) begin
          ac_s   = dmem_rdata;
          zupd_s = 1'b1;
        end else begin
          ac_s   = ac_r;
        end
      end
      default: pc_s = pc_r;
    endcase
    if (zupd_s) z_s = (ac_s == '0);
    else        z_s = z_r;
  end

  // Architectural state: PC, AC, Z and instruction register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r <= '0;
      ac_r <= '0;
      z_r  <= 1'b1;
      ir_r <= 16'h0000;
    end else begin
      pc_r <= pc_s;
      ac_r <= ac_s;
      z_r  <= z_s;
      if (state_r == ST_FETCH && imem_ack) ir_r <= imem_rdata;
    end
  end

  // General register file
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs_r[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (reg_we_s && idx_s == RIW'(i)) regs_r[i] <= reg_wd_s;
      end
    end
  end

  // Registered handshake and status outputs, decoded from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imem_req_r   <= 1'b0;
      dmem_req_r   <= 1'b0;
      dmem_we_r    <= 1'b0;
      dmem_addr_r  <= '0;
      dmem_wdata_r <= '0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      imem_req_r <= (state_s == ST_FETCH);
      dmem_req_r <= (state_s == ST_MEM);
      busy_r     <= (state_s == ST_FETCH) || (state_s == ST_EXEC) || (state_s == ST_MEM);
      done_r     <= (state_s == ST_HALT);
      if (state_r == ST_EXEC) begin
        dmem_we_r    <= (op_s == 4'h9);
        dmem_addr_r  <= rval_s[AW-1:0];
        dmem_wdata_r <= ac_r;
      end
    end
  end

  assign imem_req   = imem_req_r;
  assign imem_addr  = pc_r;
  assign dmem_req   = dmem_req_r;
  assign dmem_we    = dmem_we_r;
  assign dmem_addr  = dmem_addr_r;
  assign dmem_wdata = dmem_wdata_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign ac_out     = ac_r;

`ifdef PARAM_ACCUM_CORE_PERF_EN
  logic        start_ok_s, retire_s;
  logic [31:0] cyc_r, ret_r;

  assign start_ok_s = start && (state_r == ST_IDLE || state_r == ST_HALT);
  assign retire_s   = (state_r == ST_EXEC && op_s != 4'h8 && op_s != 4'h9) ||
                      (state_r == ST_MEM && dmem_ack);

  // Busy-cycle and retired-instruction counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_r <= 32'd0;
      ret_r <= 32'd0;
    end else if (start_ok_s) begin
      cyc_r <= 32'd0;
      ret_r <= 32'd0;
    end else begin
      if (busy_r)   cyc_r <= cyc_r + 32'd1;
      if (retire_s) ret_r <= ret_r + 32'd1;
    end
  end

  assign perf_cycles  = cyc_r;
  assign perf_retired = ret_r;
`else
  assign perf_cycles  = 32'd0;
  assign perf_retired = 32'd0;
`endif

endmodule

// File: tb/tb_param_accum_core.sv
// Randomised bench for param_accum_core against an instruction-level reference model.
module tb_param_accum_core;

  localparam int DW   = 16;
  localparam int AW   = 10;
  localparam int NREG = 6;
  localparam int RMOD = 1 << $clog2(NREG);
  localparam logic [DW-1:0] CX = 16'd3;
  localparam logic [DW-1:0] CY = 16'd7;

  logic          clk, rst_n, start;
  logic          imem_req, imem_ack;
  logic [AW-1:0] imem_addr;
  logic [15:0]   imem_rdata;
  logic          dmem_req, dmem_we, dmem_ack;
  logic [AW-1:0] dmem_addr;
  logic [DW-1:0] dmem_wdata, dmem_rdata, ac_out;
  logic          busy, done;
  logic [31:0]   perf_cycles, perf_retired;

  param_accum_core #(.DW(DW), .AW(AW), .NREG(NREG), .CORE_X(CX), .CORE_Y(CY)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .busy(busy), .done(done), .ac_out(ac_out),
    .perf_cycles(perf_cycles), .perf_retired(perf_retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0]   imem  [0:1023];
  logic [DW-1:0] dmem  [0:1023];
  logic [DW-1:0] m_mem [0:1023];
  logic [DW-1:0] m_regs[0:NREG-1];
  logic [DW-1:0] m_ac;
  logic          m_z;
  logic [AW-1:0] m_pc;
  int            m_instr, m_nmem;
  logic [31:0]   exp_st[$], act_st[$];

  int total = 0, bad = 0;
  int imem_w_fix = -1, dmem_w_fix = -1, maxw = 3;
  bit dmem_hold = 0, glitch = 0;
  int waits, stab_err, ovl_err, last_cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Memory responders: random waits, spurious acks while idle
  int ia = 0, iw = 0, ic = 0, da = 0, dw = 0, dc = 0;
  logic [AW-1:0] iaddr, daddr;
  logic [DW-1:0] dwd;
  logic          dwe;
  always @(negedge clk) begin
    if (!rst_n) begin
      imem_ack = 1'b0; dmem_ack = 1'b0; ia = 0; da = 0;
    end else begin
      if (imem_req && dmem_req) ovl_err++;
      if (imem_req) begin
        if (ia == 0) begin
          ia = 1; ic = 0; iaddr = imem_addr;
          iw = (imem_w_fix >= 0) ? imem_w_fix : $urandom_range(0, maxw);
        end
        if (imem_addr !== iaddr) stab_err++;
        if (ic == iw) begin
          imem_ack = 1'b1; imem_rdata = imem[imem_addr]; waits += iw;
        end else begin
          imem_ack = 1'b0; imem_rdata = 16'($urandom); ic++;
        end
      end else begin
        ia = 0; imem_ack = ($urandom_range(0, 3) == 0); imem_rdata = 16'($urandom);
      end
      if (dmem_req) begin
        if (da == 0) begin
          da = 1; dc = 0; daddr = dmem_addr; dwe = dmem_we; dwd = dmem_wdata;
          dw = (dmem_w_fix >= 0) ? dmem_w_fix : $urandom_range(0, maxw);
        end
        if (dmem_addr !== daddr || dmem_we !== dwe || dmem_wdata !== dwd) stab_err++;
        if (!dmem_hold && dc == dw) begin
          dmem_ack = 1'b1; waits += dw;
          if (dmem_we) begin
            act_st.push_back({6'd0, dmem_addr, dmem_wdata});
            dmem[dmem_addr] = dmem_wdata;
            dmem_rdata = 16'($urandom);
          end else begin
            dmem_rdata = dmem[dmem_addr];
          end
        end else begin
          dmem_ack = 1'b0; dmem_rdata = 16'($urandom); dc++;
        end
      end else begin
        da = 0; dmem_ack = ($urandom_range(0, 3) == 0); dmem_rdata = 16'($urandom);
      end
    end
  end

  task automatic model_reset();
    m_ac = '0; m_z = 1'b1;
    for (int i = 0; i < NREG; i++) m_regs[i] = '0;
  endtask

  // Instruction-level interpreter of the ISA
  task automatic model_run();
    logic [15:0] w; logic [3:0] op; logic [7:0] imm; logic [DW-1:0] rv; int idx;
    m_pc = '0; m_instr = 0; m_nmem = 0;
    for (int s = 0; s < 4000; s++) begin
      w = imem[m_pc]; m_pc = m_pc + 1'b1; m_instr++;
      op = w[15:12]; imm = w[7:0]; idx = int'(w[11:8]) % RMOD;
      rv = '0;
      if (idx < NREG) rv = m_regs[idx];
      case (op)
        4'h1: begin m_ac = {8'h00, imm}; m_z = (m_ac == 0); end
        4'h2: if (idx < NREG) m_regs[idx] = m_ac;
        4'h3: begin m_ac = rv;        m_z = (m_ac == 0); end
        4'h4: begin m_ac = m_ac + rv; m_z = (m_ac == 0); end
        4'h5: begin m_ac = m_ac - rv; m_z = (m_ac == 0); end
        4'h6: begin m_ac = m_ac * rv; m_z = (m_ac == 0); end
        4'h7: if (idx < NREG) m_regs[idx] = rv + 1'b1;
        4'h8: begin m_nmem++; m_ac = m_mem[rv[AW-1:0]]; m_z = (m_ac == 0); end
        4'h9: begin
          m_nmem++; m_mem[rv[AW-1:0]] = m_ac;
          exp_st.push_back({6'd0, rv[AW-1:0], m_ac});
        end
        4'hA: if (m_z) m_pc = {2'b00, imm};
        4'hB: m_pc = {2'b00, imm};
        4'hC: m_ac = imm[0] ? CY : CX;
        default: ;
      endcase
      if (op == 4'hF) break;
    end
  endtask

  task automatic run_prog(input string tag);
    int cyc;
    exp_st.delete(); act_st.delete();
    model_run();
    waits = 0; stab_err = 0; ovl_err = 0;
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    chk({tag, ":busy_run"}, busy, 1);
    cyc = 0;
    while (!done && cyc < 3000) begin
      @(posedge clk); cyc++;
      @(negedge clk);
      start = (glitch && cyc == 3 && !done);
    end
    start = 1'b0;
    last_cyc = cyc;
    chk({tag, ":done"}, done, 1);
    chk({tag, ":busy_end"}, busy, 0);
    chk({tag, ":cycles"}, cyc, 2 * m_instr + m_nmem + waits);
    chk({tag, ":ac"}, ac_out, m_ac);
    chk({tag, ":pc"}, imem_addr, m_pc);
    chk({tag, ":nstores"}, act_st.size(), exp_st.size());
    for (int i = 0; i < exp_st.size() && i < act_st.size(); i++)
      chk({tag, ":store"}, act_st[i], exp_st[i]);
    chk({tag, ":stable"}, stab_err, 0);
    chk({tag, ":overlap"}, ovl_err, 0);
`ifdef PARAM_ACCUM_CORE_PERF_EN
    chk({tag, ":perf_cycles"}, perf_cycles, cyc);
    chk({tag, ":perf_retired"}, perf_retired, m_instr);
`else
    chk({tag, ":perf_cycles"}, perf_cycles, 0);
    chk({tag, ":perf_retired"}, perf_retired, 0);
`endif
  endtask

  task automatic load(input logic [15:0] p[$]);
    for (int i = 0; i < p.size(); i++) imem[i] = p[i];
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int n, r, op, cyc;
    logic [15:0] w;
    rst_n = 1'b1; start = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    imem_rdata = 16'h0000; dmem_rdata = '0;
    for (int i = 0; i < 1024; i++) begin
      imem[i] = 16'hF000;
      dmem[i] = 16'($urandom);
      m_mem[i] = dmem[i];
    end
    model_reset();
    #1 rst_n = 1'b0;
    #1;
    chk("rst:ac", ac_out, 0);
    chk("rst:busy", busy, 0);
    chk("rst:done", done, 0);
    chk("rst:imem_req", imem_req, 0);
    chk("rst:dmem_req", dmem_req, 0);
    chk("rst:pc", imem_addr, 0);
    @(negedge clk); rst_n = 1'b1;

    imem_w_fix = 0; dmem_w_fix = 0;
    load('{16'h1005, 16'h2100, 16'h1003, 16'h4100, 16'hF000});
    run_prog("p1");
    chk("p1:ten_cycles", last_cyc, 10);
    chk("p1:ac8", ac_out, 8);

    dmem_w_fix = 2;
    load('{16'h10FF, 16'h2200, 16'h10AA, 16'h9200, 16'h1000, 16'h8200, 16'hF000});
    run_prog("p2");
    chk("p2:acAA", ac_out, 16'h00AA);

    dmem_w_fix = -1; imem_w_fix = -1;
    load('{16'h1002, 16'h2100, 16'h1001, 16'h2300, 16'h3100, 16'h5300,
           16'h2100, 16'hA009, 16'hB004, 16'hF000});
    run_prog("loop");
    load('{16'h1000, 16'hC000, 16'hA005, 16'h1011, 16'hF000, 16'hF000});
    run_prog("cid0");
    chk("cid0:ac3", ac_out, 3);
    load('{16'h1000, 16'hC001, 16'hA005, 16'h1011, 16'hF000, 16'hF000});
    run_prog("cid1");
    chk("cid1:ac7", ac_out, 7);
    load('{16'h1009, 16'h2100, 16'h1004, 16'h2600, 16'h2700, 16'h7600,
           16'h3100, 16'h4900, 16'h6100, 16'hF000});
    run_prog("nreg");

    // Reset while a store waits for its ack
    dmem_hold = 1'b1;
    load('{16'h1033, 16'h9000, 16'hF000});
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 0;
    while (!dmem_req && cyc < 50) begin @(negedge clk); cyc++; end
    chk("rstmem:req_seen", dmem_req, 1);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmem:dmem_req", dmem_req, 0);
    chk("rstmem:busy", busy, 0);
    chk("rstmem:ac", ac_out, 0);
    chk("rstmem:pc", imem_addr, 0);
    @(negedge clk); rst_n = 1'b1; dmem_hold = 1'b0;
    model_reset();
    for (int i = 0; i < 1024; i++) m_mem[i] = dmem[i];
    @(negedge clk);
    chk("rstmem:idle_done", done, 0);
    chk("rstmem:idle_busy", busy, 0);
    load('{16'h1000, 16'hF000}); // nothing: replaced below
    load('{16'hA003, 16'h1005, 16'hF000, 16'h3100, 16'hF000});
    run_prog("zrst");

    // Random forward-branching programs
    for (int t = 0; t < 25; t++) begin
      n = $urandom_range(4, 24);
      for (int i = 0; i < n; i++) begin
        op = $urandom_range(0, 14);
        r = $urandom_range(0, 15);
        if (op inside {3, 4, 5, 6, 8, 9} && (r % 8) >= NREG) r = r & 13;
        w = {4'(op), 4'(r), 8'($urandom)};
        if (op == 10 || op == 11) w[7:0] = 8'($urandom_range(i + 1, n));
        imem[i] = w;
      end
      imem[n] = 16'hF000;
      glitch = ($urandom_range(0, 1) == 1);
      if (t % 6 == 5) do_reset();
      run_prog($sformatf("rnd%0d", t));
    end
    glitch = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
